// File: rtl/jk_pkg.sv
// Shared types for the JK excitation driver: FSM states, J/K code word and its encoder.
// JK_TOGGLE_EN (in jk_excite) selects toggle encoding for transitions.
package jk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_TAIL = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic j;
    logic k;
  } jk_code_t;

  localparam jk_code_t JK_HOLD   = '{j: 1'b0, k: 1'b0};
  localparam jk_code_t JK_SET    = '{j: 1'b1, k: 1'b0};
  localparam jk_code_t JK_RESET  = '{j: 1'b0, k: 1'b1};
  localparam jk_code_t JK_TOGGLE = '{j: 1'b1, k: 1'b1};

  // Excitation needed to move a JK flop from q_now to q_next.
  function automatic jk_code_t jk_encode(input logic q_now, input logic q_next,
                                         input logic toggle_en);
    jk_code_t code;
    code = JK_HOLD;
    if (q_now != q_next) begin
      if (toggle_en)   code = JK_TOGGLE;
      else if (q_next) code = JK_SET;
      else             code = JK_RESET;
    end
    return code;
  endfunction

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Sequencer/flop-facing signal bundle of the JK excitation driver.
interface jk_excitation_driver_if #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [LEN-1:0]   pattern;
  logic             q_in;
  logic             j;
  logic             k;
  logic             ff_clr;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output start, pattern, q_in,
    input  j, k, ff_clr, busy, done, mismatch, err_cnt
  );

  modport slave (
    input  start, pattern, q_in,
    output j, k, ff_clr, busy, done, mismatch, err_cnt
  );
endinterface

// File: rtl/jk_excite.sv
// Combinational (q_now, q_next) -> J/K encoder.
// JK_TOGGLE_EN defined: transitions use toggle (j=k=1); otherwise set/reset.
module jk_excite
  import jk_pkg::*;
(
  input  logic     q_now_i,
  input  logic     q_next_i,
  output jk_code_t code_o
);

`ifdef JK_TOGGLE_EN
  localparam logic TOGGLE_EN = 1'b1;
`else
  localparam logic TOGGLE_EN = 1'b0;
`endif

  assign code_o = jk_encode(q_now_i, q_next_i, TOGGLE_EN);

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives J/K excitation for an external JK flop from a target Q pattern and checks the returned Q.
// Encoding selected by JK_TOGGLE_EN inside jk_excite; timing and checking are identical either way.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int unsigned LEN   = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  jk_excitation_driver_if.slave  bus
);

  localparam int unsigned      IDX_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [LEN-1:0]   pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             exp_q, exp_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             ff_clr_q, ff_clr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             cmp_en_c;
  jk_code_t         code_c;

  // Next-state, datapath and compare logic
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    err_d    = err_q;
    mis_d    = 1'b0;
    cmp_en_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_INIT;
          pat_d   = bus.pattern;
          idx_d   = '0;
          exp_d   = 1'b0;
          err_d   = '0;
        end
      end
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        // q_in now reflects the previous step's target, held in exp_q
        cmp_en_c = (idx_q != '0);
        exp_d    = pat_q[idx_q];
        if (idx_q == LAST_IDX) state_d = ST_TAIL;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_TAIL: begin
        cmp_en_c = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (cmp_en_c && (bus.q_in != exp_q)) begin
      mis_d = 1'b1;
      if (err_q != CNT_MAX) err_d = err_q + 1'b1;
    end

    ff_clr_d = (state_d != ST_INIT);
    busy_d   = (state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_TAIL);
    done_d   = (state_d == ST_DONE);
  end

  // Excitation for the step being entered: from the value the flop will hold to the next target bit
  jk_excite u_excite (
    .q_now_i  (exp_d),
    .q_next_i (pat_q[idx_d]),
    .code_o   (code_c)
  );

  assign j_d = (state_d == ST_RUN) && code_c.j;
  assign k_d = (state_d == ST_RUN) && code_c.k;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      pat_q    <= '0;
      idx_q    <= '0;
      exp_q    <= 1'b0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      ff_clr_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      idx_q    <= idx_d;
      exp_q    <= exp_d;
      j_q      <= j_d;
      k_q      <= k_d;
      ff_clr_q <= ff_clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
    end
  end

  assign bus.j        = j_q;
  assign bus.k        = k_q;
  assign bus.ff_clr   = ff_clr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mismatch = mis_q;
  assign bus.err_cnt  = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Randomized bench for jk_excitation_driver: behavioural JK flop, q_in fault mux, pattern-level reference model.
module tb_jk_excitation_driver;

  localparam int unsigned LEN   = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LEN16 = 16;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  jk_excitation_driver_if #(.LEN(LEN),   .CNT_W(CNT_W)) bus   ();
  jk_excitation_driver_if #(.LEN(LEN16), .CNT_W(CNT_W)) bus16 ();
  jk_excitation_driver_if #(.LEN(1),     .CNT_W(CNT_W)) bus1  ();

  jk_excitation_driver #(.LEN(LEN),   .CNT_W(CNT_W)) dut   (.clk(clk), .clr(clr), .bus(bus));
  jk_excitation_driver #(.LEN(LEN16), .CNT_W(CNT_W)) dut16 (.clk(clk), .clr(clr), .bus(bus16));
  jk_excitation_driver #(.LEN(1),     .CNT_W(CNT_W)) dut1  (.clk(clk), .clr(clr), .bus(bus1));

  // Behavioural JK flop driven by the main DUT
  logic ff_q = 1'b0;
  always @(posedge clk or negedge bus.ff_clr) begin
    if (!bus.ff_clr) ff_q <= 1'b0;
    else begin
      case ({bus.j, bus.k})
        2'b10:   ff_q <= 1'b1;
        2'b01:   ff_q <= 1'b0;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  // Fault mux: 0 good flop, 1 stuck-at-0, 2 per-cycle flip
  int   fault_mode = 0;
  logic flip = 1'b0;
  assign bus.q_in   = (fault_mode == 1) ? 1'b0 : (ff_q ^ flip);
  assign bus16.q_in = 1'b0;
  assign bus1.q_in  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp_v, $time);
    end
  endtask

  // Required {j,k} to move Q from prev to cur
  function automatic logic [1:0] model_jk(input logic prev, input logic cur);
    if (prev == cur) return 2'b00;
`ifdef JK_TOGGLE_EN
    return 2'b11;
`else
    return cur ? 2'b10 : 2'b01;
`endif
  endfunction

  // One full run; t counts cycles after the start-sampling edge
  task automatic run8(input logic [LEN-1:0] pat, input int mode,
                      input logic [LEN-1:0] mask, input bit noise);
    logic [LEN-1:0] fails;
    logic [1:0]     ejk;
    logic           prev;
    int             exp_err;
    fails   = (mode == 1) ? pat : ((mode == 2) ? mask : '0);
    exp_err = $countones(fails);
    if (exp_err > 15) exp_err = 15;
    fault_mode  = mode;
    flip        = 1'b0;
    bus.pattern = pat;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int t = 0; t <= int'(LEN) + 2; t++) begin
      if (noise) begin
        bus.start   = 1'($urandom);
        bus.pattern = LEN'($urandom);
      end
      flip = (mode == 2 && t >= 2 && t <= int'(LEN) + 1) ? mask[t-2] : 1'b0;
      ejk = 2'b00;
      if (t >= 1 && t <= int'(LEN)) begin
        prev = (t == 1) ? 1'b0 : pat[t-2];
        ejk  = model_jk(prev, pat[t-1]);
      end
      chk_eq("jk",       {30'd0, bus.j, bus.k}, {30'd0, ejk});
      chk_eq("ff_clr",   bus.ff_clr, t != 0);
      chk_eq("busy",     bus.busy,   t <= int'(LEN) + 1);
      chk_eq("done",     bus.done,   t == int'(LEN) + 2);
      chk_eq("mismatch", bus.mismatch,
             (t >= 3 && t <= int'(LEN) + 2) ? fails[t-3] : 1'b0);
      if (t == int'(LEN) + 2) chk_eq("err_cnt_done", bus.err_cnt, exp_err);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    flip      = 1'b0;
    chk_eq("idle_busy", bus.busy, 0);
    chk_eq("idle_done", bus.done, 0);
    chk_eq("err_cnt_hold", bus.err_cnt, exp_err);
  endtask

  // Single-pattern run on a secondary DUT with q_in stuck at 0
  int t_w;
  int pulses;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.pattern   = '0;
    bus16.start   = 1'b0;
    bus16.pattern = '0;
    bus1.start    = 1'b0;
    bus1.pattern  = '0;

    // Reset values
    #1 clr = 1'b0;
    #1;
    chk_eq("rst_jk",       {bus.j, bus.k}, 0);
    chk_eq("rst_ff_clr",   bus.ff_clr, 1);
    chk_eq("rst_busy",     bus.busy, 0);
    chk_eq("rst_done",     bus.done, 0);
    chk_eq("rst_mismatch", bus.mismatch, 0);
    chk_eq("rst_err_cnt",  bus.err_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1;

    // Directed patterns
    run8(8'b1010_1010, 0, '0, 1'b0);
    run8(8'hFF,        1, '0, 1'b0);
    run8(8'b0110_0101, 0, '0, 1'b1);
    run8(8'b0000_0110, 0, '0, 1'b0);

    // Async reset during RUN step 3 with errors pending
    fault_mode  = 1;
    bus.pattern = 8'hFF;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_eq("pre_rst_err", bus.err_cnt, 2);
    @(negedge clk) clr = 1'b0;
    #1;
    chk_eq("mid_rst_jk",       {bus.j, bus.k}, 0);
    chk_eq("mid_rst_ff_clr",   bus.ff_clr, 1);
    chk_eq("mid_rst_busy",     bus.busy, 0);
    chk_eq("mid_rst_mismatch", bus.mismatch, 0);
    chk_eq("mid_rst_err_cnt",  bus.err_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_eq("mid_rst_done", bus.done, 0);
    end
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1;
    run8(8'b0000_0110, 0, '0, 1'b0);

    // Randomized back-to-back runs
    for (int r = 0; r < 24; r++)
      run8(LEN'($urandom), int'($urandom_range(0, 2)), LEN'($urandom), 1'($urandom));

    // Counter saturation on a 16-bit pattern with q_in stuck at 0
    bus16.pattern = 16'hFFFF;
    bus16.start   = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    t_w    = 0;
    pulses = 0;
    while (!bus16.done && t_w < 60) begin
      @(posedge clk); #1;
      t_w++;
      if (bus16.mismatch) pulses++;
    end
    chk_eq("sat_latency", t_w, LEN16 + 2);
    chk_eq("sat_pulses",  pulses, LEN16);
    chk_eq("sat_err_cnt", bus16.err_cnt, 15);
    @(posedge clk); #1;
    chk_eq("sat_idle", {bus16.j, bus16.k, bus16.ff_clr, bus16.busy}, 4'b0010);

    // Single-bit run: one compare, in TAIL
    bus1.pattern = 1'b1;
    bus1.start   = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    t_w    = 0;
    pulses = 0;
    while (!bus1.done && t_w < 20) begin
      @(posedge clk); #1;
      t_w++;
      if (bus1.mismatch) pulses++;
    end
    chk_eq("len1_latency", t_w, 3);
    chk_eq("len1_pulses",  pulses, 1);
    chk_eq("len1_err_cnt", bus1.err_cnt, 1);
    @(posedge clk); #1;
    chk_eq("len1_idle", {bus1.j, bus1.k, bus1.ff_clr, bus1.busy}, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
